seg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment scan driver, replacing the fixed 8-digit MM:SS.CC display controller. It displays N hex digits, each with its own decimal-point, blank and blink controls. Brightness is set by 16-level PWM, and the block inserts anti-ghosting dead time. Inputs are latched once per frame so the display never tears. It sits between the timekeeping/formatting logic and the board's seg/dp/an pins, and derives scan timing from the system clock with no separate refresh clock.

---
 rtl/seg_disp_pkg.sv | 34 +++
 rtl/seg_hex_decoder.sv | 11 +
 rtl/seg_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low cathode pattern {g,f,e,d,c,b,a}; code F shows "F", never blank.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  function automatic int on_unit(input int slot_cycles, input int dead_cycles);
    return (slot_cycles - dead_cycles) / 16;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-7-segment decoder.
module seg_hex_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with PWM brightness, dead time,
// per-digit blank/blink/dp and once-per-frame input snapshots.
module seg_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int DEAD_CYCLES  = 64,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int SW      = $clog2(SLOT_CYCLES);
  localparam int BW      = SW + 1;
  localparam int DW      = $clog2(N_DIGITS);
  localparam int BCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int ON_UNIT = on_unit(SLOT_CYCLES, DEAD_CYCLES);

  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]           digit_idx_q, digit_idx_d;
  logic [BCW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                    blink_wrap_q, blink_wrap_d;
  logic                    blink_off_q, blink_off_d;

  logic [4*N_DIGITS-1:0]   digits_sh_q, digits_sh_d;
  logic [N_DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic [N_DIGITS-1:0]     blank_sh_q, blank_sh_d;
  logic [N_DIGITS-1:0]     blink_sh_q, blink_sh_d;
  logic [3:0]              brightness_sh_q, brightness_sh_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic                    frame_edge, slot_wrap, frame_end;
  logic                    visible, anode_on;
  logic [BW-1:0]           slot_ext, pwm_bound;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;

  seg_hex_decoder u_hex_decoder (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Blink wrap is noted at frame end and applied on the following capture edge.
  always_comb begin
    frame_edge = (slot_cnt_q == '0) && (digit_idx_q == '0);
    slot_wrap  = (slot_cnt_q == SW'(SLOT_CYCLES - 1));
    frame_end  = slot_wrap && (digit_idx_q == DW'(N_DIGITS - 1));

    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_idx_d = digit_idx_q;
    if (slot_wrap) begin
      digit_idx_d = (digit_idx_q == DW'(N_DIGITS - 1)) ? '0 : digit_idx_q + DW'(1);
    end

    blink_cnt_d  = blink_cnt_q;
    blink_wrap_d = blink_wrap_q;
    blink_off_d  = blink_off_q;
    if (frame_end) begin
      if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d  = '0;
        blink_wrap_d = 1'b1;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
    if (frame_edge && blink_wrap_q) begin
      blink_off_d  = ~blink_off_q;
      blink_wrap_d = 1'b0;
    end

    digits_sh_d     = digits_sh_q;
    dp_sh_d         = dp_sh_q;
    blank_sh_d      = blank_sh_q;
    blink_sh_d      = blink_sh_q;
    brightness_sh_d = brightness_sh_q;
    if (frame_edge) begin
      digits_sh_d     = digits;
      dp_sh_d         = dp;
      blank_sh_d      = blank;
      blink_sh_d      = blink;
      brightness_sh_d = brightness;
    end
  end

  // PWM window compare is done one bit wider than slot_cnt so the bound never wraps.
  always_comb begin
    cur_hex   = digits_sh_q[digit_idx_q*4 +: 4];
    visible   = !blank_sh_q[digit_idx_q] && !(blink_sh_q[digit_idx_q] && blink_off_q);
    slot_ext  = {1'b0, slot_cnt_q};
    pwm_bound = BW'(DEAD_CYCLES + (int'(brightness_sh_q) + 1) * ON_UNIT);
    anode_on  = visible && (slot_ext >= BW'(DEAD_CYCLES)) && (slot_ext < pwm_bound);

    seg_d         = SEG_BLANK;
    dp_n_d        = 1'b1;
    an_d          = '1;
    frame_start_d = frame_edge;
    if (anode_on) begin
      seg_d  = cur_seg;
      dp_n_d = !dp_sh_q[digit_idx_q];
      for (int i = 0; i < N_DIGITS; i++) begin
        an_d[i] = (digit_idx_q != DW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q      <= '0;
      digit_idx_q     <= '0;
      blink_cnt_q     <= '0;
      blink_wrap_q    <= 1'b0;
      blink_off_q     <= 1'b0;
      digits_sh_q     <= '0;
      dp_sh_q         <= '0;
      blank_sh_q      <= '1;
      blink_sh_q      <= '0;
      brightness_sh_q <= '0;
      seg_q           <= SEG_BLANK;
      dp_n_q          <= 1'b1;
      an_q            <= '1;
      frame_start_q   <= 1'b0;
    end else begin
      slot_cnt_q      <= slot_cnt_d;
      digit_idx_q     <= digit_idx_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_wrap_q    <= blink_wrap_d;
      blink_off_q     <= blink_off_d;
      digits_sh_q     <= digits_sh_d;
      dp_sh_q         <= dp_sh_d;
      blank_sh_q      <= blank_sh_d;
      blink_sh_q      <= blink_sh_d;
      brightness_sh_q <= brightness_sh_d;
      seg_q           <= seg_d;
      dp_n_q          <= dp_n_d;
      an_q            <= an_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 68-cycle slots).
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int SLOT  = 68;
  localparam int DEAD  = 4;
  localparam int BF    = 2;
  localparam int UNIT  = 4;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [3:0]    blink_in = '0;
  logic [3:0]    bright_in = '0;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_start;

  int n_checks = 0;
  int n_fail = 0;
  int low_cnt[8][4];
  int dp_disagree;
  int dp_low;

  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp, snap_blank, snap_blink, snap_bright;

  seg_scan_driver #(
    .N_DIGITS     (N),
    .SLOT_CYCLES  (SLOT),
    .DEAD_CYCLES  (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits_in),
    .dp          (dp_in),
    .blank       (blank_in),
    .blink       (blink_in),
    .brightness  (bright_in),
    .seg         (seg),
    .dp_n        (dp_n),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_hex(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Holds reset with new inputs, checks the reset values, then releases mid-cycle.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] bl, input logic [3:0] bk,
                               input logic [3:0] br);
    rst_n     = 1'b0;
    digits_in = d;
    dp_in     = p;
    blank_in  = bl;
    blink_in  = bk;
    bright_in = br;
    repeat (2) @(negedge clk);
    checkOutput("rst an", int'(an), 4'hF);
    checkOutput("rst seg", int'(seg), 7'h7F);
    checkOutput("rst dp_n", int'(dp_n), 1);
    checkOutput("rst frame_start", int'(frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // State s is what the counters held at the edge that produced the sampled outputs.
  task automatic runFrames(input int scen, input int n_frames);
    int slot, dig, fr;
    logic boff, on;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_dp;
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < 4; b++) low_cnt[f][b] = 0;
    dp_disagree = 0;
    dp_low = 0;
    for (int s = 0; s < n_frames * FRAME; s++) begin
      if (scen == 3 && s == 2) digits_in = 16'hABCD;
      if (s % FRAME == 0) begin
        snap_digits = digits_in;
        snap_dp     = dp_in;
        snap_blank  = blank_in;
        snap_blink  = blink_in;
        snap_bright = bright_in;
      end
      @(posedge clk);
      #1;
      slot = s % SLOT;
      dig  = (s / SLOT) % N;
      fr   = s / FRAME;
      boff = ((fr / BF) % 2) == 1;
      on   = (slot >= DEAD) && (slot < DEAD + (int'(snap_bright) + 1) * UNIT) &&
             !snap_blank[dig] && !(snap_blink[dig] && boff);
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      if (on) begin
        exp_an[dig] = 1'b0;
        exp_seg     = ref_hex(snap_digits[dig*4 +: 4]);
        exp_dp      = !snap_dp[dig];
      end
      checkOutput($sformatf("an s=%0d", s), int'(an), int'(exp_an));
      checkOutput($sformatf("seg s=%0d", s), int'(seg), int'(exp_seg));
      checkOutput($sformatf("dp_n s=%0d", s), int'(dp_n), int'(exp_dp));
      checkOutput($sformatf("frame_start s=%0d", s), int'(frame_start), (s % FRAME == 0) ? 1 : 0);
      for (int b = 0; b < 4; b++)
        if (!an[b]) low_cnt[fr][b]++;
      if ((dp_n == 1'b0) != (an[1] == 1'b0)) dp_disagree++;
      if (!dp_n) dp_low++;
      if (scen == 1) begin
        if (s == 3)   checkOutput("dead before digit0", int'(an), 4'hF);
        if (s == 4)   checkOutput("digit0 an", int'(an), 4'b1110);
        if (s == 4)   checkOutput("digit0 seg", int'(seg), 7'b1000000);
        if (s == 68)  checkOutput("dead before digit1", int'(an), 4'hF);
        if (s == 72)  checkOutput("digit1 seg", int'(seg), 7'b1111001);
        if (s == 140) checkOutput("digit2 an", int'(an), 4'b1011);
        if (s == 208) checkOutput("digit3 seg", int'(seg), 7'b0110000);
      end
      if (scen == 3) begin
        if (s == 72)        checkOutput("old digit1 kept", int'(seg), 7'b1111001);
        if (s == FRAME + 4) checkOutput("new digit0 D", int'(seg), 7'b0100001);
        if (s == FRAME + 212) checkOutput("new digit3 A", int'(seg), 7'b0001000);
      end
    end
  endtask

  initial begin
    // Basic scan, full brightness, then asynchronous reset mid-pulse.
    applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd15);
    runFrames(1, 2);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("bright15 low an%0d", b), low_cnt[0][b], 64);
    checkOutput("pre-reset an lit", int'(an), 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst an", int'(an), 4'hF);
    checkOutput("async rst seg", int'(seg), 7'h7F);
    checkOutput("async rst dp_n", int'(dp_n), 1);

    applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd0);
    runFrames(2, 1);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("bright0 low an%0d", b), low_cnt[0][b], 4);

    applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd7);
    runFrames(2, 1);
    for (int b = 0; b < 4; b++) checkOutput($sformatf("bright7 low an%0d", b), low_cnt[0][b], 32);

    applyStimulus(16'h3210, 4'b0000, 4'b0000, 4'b0000, 4'd15);
    runFrames(3, 2);

    applyStimulus(16'h3210, 4'b0000, 4'b1000, 4'b0100, 4'd15);
    runFrames(4, 6);
    checkOutput("blink f0", low_cnt[0][2], 64);
    checkOutput("blink f1", low_cnt[1][2], 64);
    checkOutput("blink f2", low_cnt[2][2], 0);
    checkOutput("blink f3", low_cnt[3][2], 0);
    checkOutput("blink f4", low_cnt[4][2], 64);
    checkOutput("blink f5", low_cnt[5][2], 64);
    checkOutput("blank an3", low_cnt[0][3] + low_cnt[2][3] + low_cnt[5][3], 0);

    applyStimulus(16'h3210, 4'b0010, 4'b0000, 4'b0000, 4'd15);
    runFrames(5, 1);
    checkOutput("dp follows an1", dp_disagree, 0);
    checkOutput("dp low cycles", dp_low, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
